vga_text_render: RTL
====================

Name: vga_text_render

Overview:
- Pixel stage directly downstream of the 640x480 VGA timing generator; consumes hc, vc, vidon, Hsync and Vsync.
- Renders an 80x30 text screen of 8x16 glyphs, reading an external character RAM and an external font ROM. Both have 1-cycle synchronous reads.
- Adds a blinking underline cursor and drives registered 8-bit RGB (3-3-2) plus syncs, all aligned to the pipeline latency.

Parameters:
- HBP, 144, hc value that maps to pixel column x=0.
- VBP, 31, vc value that maps to pixel row y=0.
- COLS, 80, text columns.
- ROWS, 30, text rows.
- BLINK_LOG2, 5, cursor blink period is 2^BLINK_LOG2 frames; the cursor is visible for the first half.

Ports:
- clk  in  1  pixel clock (25 MHz), same clock as the timing generator
- rst  in  1  asynchronous, active-high reset
- hc  in  10  horizontal counter from the timing generator
- vc  in  10  vertical counter from the timing generator
- hsync_i  in  1  Hsync from the timing generator, active low
- vsync_i  in  1  Vsync from the timing generator, active low
- vidon_i  in  1  active-video flag from the timing generator
- char_addr  out  12  char RAM read address = row*COLS+col
- char_data  in  8  char RAM read data, valid 1 clk after char_addr; [6:0] = glyph code, [7] = inverse-video
- font_addr  out  11  font ROM address = {glyph[6:0], glyph_row[3:0]}
- font_data  in  8  font ROM row bits, valid 1 clk after font_addr; bit7 = leftmost pixel
- cursor_col  in  7  cursor column, 0..79
- cursor_row  in  5  cursor row, 0..29
- cursor_en  in  1  cursor enable
- fg_color  in  8  foreground RGB332
- bg_color  in  8  background RGB332
- hsync_o  out  1  Hsync delayed 3 clk
- vsync_o  out  1  Vsync delayed 3 clk
- vidon_o  out  1  vidon delayed 3 clk
- rgb  out  8  pixel colour, registered

Behaviour:
- Reset (async): hsync_o=1, vsync_o=1, vidon_o=0, rgb=0, char_addr=0, font_addr=0, all pipeline registers 0, blink counter 0, vsync edge register 1.
- Coordinates: x = hc-HBP, y = vc-VBP, both 10-bit modulo. col = x[9:3], row = y[8:4], glyph_row = y[3:0], bit index = x[2:0].
- S0 (cycle n): register char_addr = row*80+col, computed as (row<<6)+(row<<4)+col in 12 bits. Also register col, row, glyph_row, bit index, vidon, syncs, and in_range = (col<COLS)&&(row<ROWS).
- S1 (cycle n+1): char_data is valid. Register font_addr = {char_data[6:0], glyph_row} and the inverse bit; forward the remaining side-band.
- S2 (cycle n+2): font_data is valid. pix = font_data[7-bit index].
  - Cursor hit = cursor_en && blink_on && col==cursor_col && row==cursor_row && glyph_row>=14.
  - on = (pix ^ inverse ^ cursor hit) && in_range.
- S3 (cycle n+3): rgb = vidon_d ? (on ? fg_color : bg_color) : 0. hsync_o, vsync_o and vidon_o are updated in the same edge.
- Latency: exactly 3 clk from any input sample to its effect on rgb and the sync outputs. Out-of-range cells never read char_data into the colour decision: they render bg_color when vidon_d=1.
- Blink:
  - frame_tick = rising edge of vsync_i (registered previous value 0, current 1).
  - On each tick the BLINK_LOG2-bit counter increments and wraps from 2^BLINK_LOG2-1 to 0.
  - blink_on = ~counter[MSB].
- cursor_*, fg_color and bg_color are sampled combinationally at the stage that uses them. Mid-frame changes take effect at the next pixel and are not glitch-protected.
- Reset mid-frame: outputs are forced to their reset values at once. The pipeline refills within 3 clk after reset deasserts, and the blink phase restarts at visible.
- No handshake exists: memories are assumed to always return data in 1 clk and the pipeline never stalls.

Decomposition:
- Package vga_pkg: HBP, VBP, COLS, ROWS, GLYPH_W=8, GLYPH_H=16, CURSOR_FIRST_ROW=14, RGB332 width.
- Sub-module vga_sync_delay: a parameterised N-stage shift register for {hsync, vsync, vidon}, reset to {1,1,0}. It is instantiated with N=3.

Test Plan:
- Reset release with hc=0, vc=0 -> hsync_o=1, vsync_o=1, vidon_o=0, rgb=0 until the first sample propagates at clk 3; hsync_o then equals hsync_i delayed 3.
- hc=144+8*5+2, vc=31+16*3+4, vidon=1 -> char_addr=245 next clk. Feed char_data=0x41 -> font_addr={0x41,4}=0x414. Feed font_data=0x20 (bit5) -> rgb=fg_color at clk n+3.
- Same stimulus with char_data=0xC1 (inverse) -> rgb=bg_color.
- vidon=0 with font_data=0xFF -> rgb=0 at n+3.
- cursor_en=1, cursor at (5,3), glyph_row 15, font_data=0 -> rgb=fg for 16 frames, bg for the next 16 (32 vsync rising edges); glyph_row 13 -> always bg.
- Assert rst mid-line -> rgb=0 and hsync_o=1 immediately. The blink counter returns to 0 and the cursor is visible in the first frame after reset.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and stage bundle for the VGA text renderer.
package vga_pkg;

  localparam int HBP              = 144;
  localparam int VBP              = 31;
  localparam int COLS             = 80;
  localparam int ROWS             = 30;
  localparam int GLYPH_W          = 8;
  localparam int GLYPH_H          = 16;
  localparam int CURSOR_FIRST_ROW = 14;
  localparam int RGB_W            = 8;
  localparam int BLINK_LOG2       = 5;

  typedef struct packed {
    logic [6:0] col;
    logic [4:0] row;
    logic [3:0] grow;
    logic [2:0] bidx;
    logic       inr;
  } pos_t;

endpackage

// File: rtl/vga_text_render_if.sv
// Character RAM and font ROM read ports of the text renderer.
interface vga_text_render_if;

  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output char_addr,
    output font_addr,
    input  char_data,
    input  font_data
  );

  modport slave (
    input  char_addr,
    input  font_addr,
    output char_data,
    output font_data
  );

endinterface

// File: rtl/vga_sync_delay.sv
// N-stage delay line for {hsync, vsync, vidon}; o_tap is the
// value one stage before the output.
module vga_sync_delay #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_sync,
  output logic [2:0] o_sync,
  output logic [2:0] o_tap
);

  logic [2:0] r_sr [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_sr[i] <= 3'b110;
    end else begin
      r_sr[0] <= i_sync;
      for (int i = 1; i < N; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_sync = r_sr[N-1];
  assign o_tap  = r_sr[N-2];

endmodule

// File: rtl/vga_text_render.sv
// 80x30 text pixel pipeline: address, glyph fetch, font fetch,
// then registered RGB332 with syncs delayed to match.
module vga_text_render
  import vga_pkg::*;
#(
  parameter int P_HBP        = HBP,
  parameter int P_VBP        = VBP,
  parameter int P_COLS       = COLS,
  parameter int P_ROWS       = ROWS,
  parameter int P_BLINK_LOG2 = BLINK_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             vidon_i,
  vga_text_render_if.master mem,
  input  logic [6:0]       cursor_col,
  input  logic [4:0]       cursor_row,
  input  logic             cursor_en,
  input  logic [RGB_W-1:0] fg_color,
  input  logic [RGB_W-1:0] bg_color,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             vidon_o,
  output logic [RGB_W-1:0] rgb
);

  logic [9:0]  w_x;
  logic [8:0]  w_y;
  pos_t        w_pos;
  logic [11:0] w_addr;

  assign w_x = hc - 10'(P_HBP);
  assign w_y = vc[8:0] - 9'(P_VBP);

  assign w_pos.col  = w_x[9:3];
  assign w_pos.row  = w_y[8:4];
  assign w_pos.grow = w_y[3:0];
  assign w_pos.bidx = w_x[2:0];
  assign w_pos.inr  = (w_x[9:3] < 7'(P_COLS))
                   && (w_y[8:4] < 5'(P_ROWS));

  // row*80 as shifts keeps this a pair of adders
  assign w_addr = 12'({w_pos.row, 6'b0})
                + 12'({w_pos.row, 4'b0})
                + 12'(w_pos.col);

  pos_t             r_a, r_b;
  logic [11:0]      r_char_addr;
  logic [10:0]      r_font_addr;
  logic             r_inv;
  logic [RGB_W-1:0] r_rgb;

  logic                  r_vs_prev;
  logic [P_BLINK_LOG2-1:0] r_blink;
  logic                  w_tick;
  logic                  w_blink_on;

  logic [2:0]       w_tap;
  logic             w_pix;
  logic             w_hit;
  logic             w_on;
  logic [RGB_W-1:0] w_rgb;

  assign w_tick     = ~r_vs_prev & vsync_i;
  assign w_blink_on = ~r_blink[P_BLINK_LOG2-1];

  assign w_pix = mem.font_data[3'd7 - r_b.bidx];
  assign w_hit = cursor_en && w_blink_on
              && (r_b.col == cursor_col)
              && (r_b.row == cursor_row)
              && (r_b.grow >= 4'(CURSOR_FIRST_ROW));
  assign w_on  = (w_pix ^ r_inv ^ w_hit) && r_b.inr;
  assign w_rgb = w_tap[0] ? (w_on ? fg_color : bg_color)
                          : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_char_addr <= '0;
      r_font_addr <= '0;
      r_inv       <= 1'b0;
      r_rgb       <= '0;
      r_vs_prev   <= 1'b1;
      r_blink     <= '0;
    end else begin
      r_a         <= w_pos;
      r_char_addr <= w_addr;
      r_b         <= r_a;
      r_font_addr <= {mem.char_data[6:0], r_a.grow};
      r_inv       <= mem.char_data[7];
      r_rgb       <= w_rgb;
      r_vs_prev   <= vsync_i;
      if (w_tick) r_blink <= r_blink + 1'b1;
    end
  end

  assign mem.char_addr = r_char_addr;
  assign mem.font_addr = r_font_addr;
  assign rgb           = r_rgb;

  vga_sync_delay #(.N(3)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sync ({hsync_i, vsync_i, vidon_i}),
    .o_sync ({hsync_o, vsync_o, vidon_o}),
    .o_tap  (w_tap)
  );

endmodule
